// File: rtl/kulisch_to_log.sv
// Converts a fixed-point Kulisch accumulator word into an unpacked log-domain number.
// Build option KULISCH_TO_LOG_INEXACT_EN adds out_inexact (rounding or flush lost information).
module kulisch_to_log #(
  parameter int M                  = 5,
  parameter int F                  = 10,
  parameter int LINEAR_TO_LOG_BITS = 8,
  parameter int ACC_NON_FRAC       = 16,
  parameter int ACC_FRAC           = 16
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic signed [ACC_NON_FRAC+ACC_FRAC-1:0]      in_bits,
  input  logic                                         in_is_inf,
  input  logic                                         in_overflow,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_sign,
  output logic                                         out_is_zero,
  output logic                                         out_is_inf,
`ifdef KULISCH_TO_LOG_INEXACT_EN
  output logic                                         out_inexact,
`endif
  output logic signed [M+F-1:0]                        out_log_exp
);

  localparam int W     = ACC_NON_FRAC + ACC_FRAC;
  localparam int L     = LINEAR_TO_LOG_BITS;
  localparam int PW    = $clog2(W);
  localparam int EW    = PW + 2;
  localparam int RQ    = 31;
  localparam int RX    = 10;
  localparam int E_MAX = 2**(M-1) - 1;
  localparam int E_MIN = -(2**(M-1));

  typedef enum logic [2:0] {IDLE, ABS, LZC, LOG, OUT} state_t;
  state_t state;

  // log2(1 + idx/2^L) in F fractional bits, rounded to nearest, by repeated squaring.
  function automatic logic [F:0] log_rom_entry(input int idx);
    longint unsigned y;
    longint unsigned t;
    t = 64'd0;
    y = 64'(2**L + idx) << (RQ - L);
    for (int k = 0; k < F + RX; k++) begin
      y = (y * y) >> RQ;
      t = t << 1;
      if (y >= (64'd2 << RQ)) begin
        t = t | 64'd1;
        y = y >> 1;
      end
    end
    t = (t + (64'd1 << (RX - 1))) >> RX;
    return (F+1)'(t);
  endfunction

  function automatic logic [L:0] round_half_up(input logic [L-1:0] idx, input logic guard);
    return {1'b0, idx} + {{L{1'b0}}, guard};
  endfunction

  logic [F:0] rom [2**L];
  for (genvar g = 0; g < 2**L; g++) begin : g_rom
    assign rom[g] = log_rom_entry(g);
  end

  logic signed [W-1:0]  bits_p0;
  logic                 inf_p0;
  logic [W-1:0]         mag_p1;
  logic [L-1:0]         idx_p2;
  logic signed [EW-1:0] e_p2;
  logic                 zero_p2;

  logic [PW-1:0] lead;
  logic [W-1:0]  norm;
  logic          guard;
  logic [L:0]    rnd;
  int            e_int;

  // Leading-one detect, normalise the leading one to the MSB, round the mantissa index
  always_comb begin
    lead = '0;
    for (int i = 0; i < W; i++)
      if (mag_p1[i]) lead = PW'(i);
    norm  = mag_p1 << (W - 1 - int'(lead));
    guard = norm[W-2-L];
    rnd   = round_half_up(norm[W-2 -: L], guard);
    e_int = int'(lead) - ACC_FRAC + int'(rnd[L]);
  end

`ifdef KULISCH_TO_LOG_INEXACT_EN
  logic sticky;
  logic inx_p2;
  logic res_inexact;
  assign sticky = |norm[W-3-L:0];
`endif

  always_ff @(posedge clock) begin
    if (state == IDLE && in_valid) begin
      bits_p0 <= in_bits;
      inf_p0  <= in_is_inf | in_overflow;
    end
    // ABS -> LZC: magnitude; the most-negative word maps to 2^(W-1)
    if (state == ABS)
      mag_p1 <= bits_p0[W-1] ? $unsigned(-bits_p0) : $unsigned(bits_p0);
    // LZC -> LOG: rounded index, exponent, zero flag
    if (state == LZC) begin
      idx_p2  <= rnd[L-1:0];
      e_p2    <= EW'(e_int);
      zero_p2 <= ~norm[W-1];
`ifdef KULISCH_TO_LOG_INEXACT_EN
      inx_p2  <= guard | sticky;
`endif
    end
  end

  logic                  res_sign;
  logic                  res_zero;
  logic                  res_inf;
  logic signed [M+F-1:0] res_exp;
  int                    exp_int;

  // Special cases in priority order: input inf/overflow, zero, exponent overflow, underflow flush
  always_comb begin
    exp_int  = int'(e_p2) * (2**F) + int'(rom[idx_p2]);
    res_sign = bits_p0[W-1];
    res_zero = 1'b0;
    res_inf  = 1'b0;
    res_exp  = (M+F)'(exp_int);
`ifdef KULISCH_TO_LOG_INEXACT_EN
    res_inexact = inx_p2;
`endif
    if (inf_p0) begin
      res_inf = 1'b1;
      res_exp = '0;
    end else if (zero_p2) begin
      res_zero = 1'b1;
      res_sign = 1'b0;
      res_exp  = '0;
    end else if (int'(e_p2) > E_MAX) begin
      res_inf = 1'b1;
      res_exp = '0;
    end else if (int'(e_p2) < E_MIN) begin
      res_zero = 1'b1;
      res_sign = 1'b0;
      res_exp  = '0;
`ifdef KULISCH_TO_LOG_INEXACT_EN
      res_inexact = 1'b1;
`endif
    end
  end

  assign in_ready = (state == IDLE) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_is_zero <= 1'b0;
      out_is_inf  <= 1'b0;
      out_log_exp <= '0;
`ifdef KULISCH_TO_LOG_INEXACT_EN
      out_inexact <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) state <= ABS;
        ABS:  state <= LZC;
        LZC:  state <= LOG;
        // LOG -> OUT: result fields registered here and held until consumed
        LOG: begin
          state       <= OUT;
          out_valid   <= 1'b1;
          out_sign    <= res_sign;
          out_is_zero <= res_zero;
          out_is_inf  <= res_inf;
          out_log_exp <= res_exp;
`ifdef KULISCH_TO_LOG_INEXACT_EN
          out_inexact <= res_inexact;
`endif
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kulisch_to_log.sv
// Table-driven bench for kulisch_to_log with a scoreboard queue of expected results.
module tb_kulisch_to_log;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_bits;
  logic               in_is_inf;
  logic               in_overflow;
  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic               out_is_zero;
  logic               out_is_inf;
`ifdef KULISCH_TO_LOG_INEXACT_EN
  logic               out_inexact;
`endif
  logic signed [14:0] out_log_exp;

  always #5 clock = ~clock;

  kulisch_to_log dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .in_is_inf   (in_is_inf),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_is_zero (out_is_zero),
    .out_is_inf  (out_is_inf),
`ifdef KULISCH_TO_LOG_INEXACT_EN
    .out_inexact (out_inexact),
`endif
    .out_log_exp (out_log_exp)
  );

  typedef struct packed {
    logic [31:0] bits;
    logic        i_inf;
    logic        i_ovf;
    logic        sign;
    logic        zero;
    logic        is_inf;
    int          log_exp;
    logic        inx;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  vec_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic compare_out(input int id);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d scoreboard: got output, required nothing queued", id);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d sign", id), out_sign, e.sign);
    check($sformatf("v%0d is_zero", id), out_is_zero, e.zero);
    check($sformatf("v%0d is_inf", id), out_is_inf, e.is_inf);
    if (!e.is_inf)
      check($sformatf("v%0d log_exp", id), longint'(out_log_exp), longint'(e.log_exp));
`ifdef KULISCH_TO_LOG_INEXACT_EN
    check($sformatf("v%0d inexact", id), out_inexact, e.inx);
`endif
  endtask

  // Waits for out_valid, counting cycles from the accept edge; returns the count.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_vec(input int id);
    int n;
    @(negedge clock);
    check($sformatf("v%0d in_ready_idle", id), in_ready, 1);
    in_bits     = vecs[id].bits;
    in_is_inf   = vecs[id].i_inf;
    in_overflow = vecs[id].i_ovf;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    exp_q.push_back(vecs[id]);
    @(negedge clock);
    in_valid    = 1'b0;
    in_is_inf   = 1'b0;
    in_overflow = 1'b0;
    wait_out(n);
    check($sformatf("v%0d latency", id), n, 4);
    if (out_valid) compare_out(id);
    else void'(exp_q.pop_front());
    @(negedge clock);
    check($sformatf("v%0d out_valid_drop", id), out_valid, 0);
    check($sformatf("v%0d in_ready_after", id), in_ready, 1);
  endtask

  initial begin
    int n;
    vecs[0]  = '{32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,      0, 1'b0};
    vecs[1]  = '{32'hFFFD_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,   1623, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  15360, 1'b1};
    vecs[3]  = '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  15360, 1'b0};
    vecs[4]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,      0, 1'b0};
    vecs[5]  = '{32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,      0, 1'b0};
    vecs[6]  = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -16384, 1'b0};
    vecs[7]  = '{32'h0005_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,   2378, 1'b0};
    vecs[8]  = '{32'h0000_C000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,   -425, 1'b0};
    vecs[9]  = '{32'hFFFF_8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  -1024, 1'b0};
    vecs[10] = '{32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,      0, 1'b0};
    vecs[11] = '{32'h0001_0180, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,     11, 1'b1};

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_bits     = '0;
    in_is_inf   = 1'b0;
    in_overflow = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset out_sign", out_sign, 0);
    check("reset out_is_zero", out_is_zero, 0);
    check("reset out_is_inf", out_is_inf, 0);
    check("reset out_log_exp", longint'(out_log_exp), 0);
    reset = 1'b0;
    @(negedge clock);
    check("in_ready after reset", in_ready, 1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: hold the result, ignore a new offer, release on out_ready
    @(negedge clock);
    in_bits   = vecs[7].bits;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    exp_q.push_back(vecs[7]);
    @(negedge clock);
    in_bits = 32'h0002_0000;
    wait_out(n);
    check("bp latency", n, 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("bp%0d out_valid", k), out_valid, 1);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
      check($sformatf("bp%0d log_exp", k), longint'(out_log_exp), longint'(vecs[7].log_exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (out_valid) compare_out(7);
    else void'(exp_q.pop_front());
    @(negedge clock);
    check("bp in_ready next", in_ready, 1);
    check("bp out_valid next", out_valid, 0);
    repeat (6) @(negedge clock);
    check("bp offer ignored", out_valid, 0);

    // Reset while converting: result dropped, outputs cleared
    @(negedge clock);
    in_bits  = vecs[1].bits;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_lzc log_exp immediate", longint'(out_log_exp), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_lzc in_ready", in_ready, 1);
    check("rst_lzc out_valid", out_valid, 0);
    check("rst_lzc out_sign", out_sign, 0);
    repeat (6) @(negedge clock);
    check("rst_lzc dropped", out_valid, 0);
    run_vec(1);
    run_vec(8);

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
